// File: rtl/regfile_param.sv
// Parameterised register file: two combinational read ports, two write ports, bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we4,
    input  logic [AW-1:0]    wa4,
    input  logic [WIDTH-1:0] wd4,
    input  logic             clr,
    output logic             busy
);

    // Handshake: clr is a single-cycle request accepted only in IDLE;
    // busy stays high for the DEPTH cycles of the clear, during which
    // write enables and further clr requests are dropped.
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Address exists and is not the hardwired zero register.
    function automatic logic live(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        v = '0;
        if (live(ra)) v = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (state_q == IDLE) begin
            if (we3 && live(wa3) && (wa3 == ra)) v = wd3;
            if (we4 && live(wa4) && (wa4 == ra)) v = wd4;
        end
`endif
        return v;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    assign busy = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                if (32'(idx_q) == DEPTH - 1) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Port B is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state_q == IDLE) begin
            if (we3 && live(wa3)) mem[wa3] <= wd3;
            if (we4 && live(wa4)) mem[wa4] <= wd4;
        end else begin
            mem[idx_q] <= '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters).
module tb_regfile_param;

    localparam int WIDTH = 32;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [AW-1:0]    ra1 = '0, ra2 = '0;
    logic [WIDTH-1:0] rd1, rd2;
    logic             we3 = 1'b0, we4 = 1'b0;
    logic [AW-1:0]    wa3 = '0, wa4 = '0;
    logic [WIDTH-1:0] wd3 = '0, wd4 = '0;
    logic             clr = 1'b0;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_param dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .clr(clr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Driver: one write through port A, applied at a negedge, committed at the next posedge.
    task automatic write_a(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        we3 = 1'b1; wa3 = a; wd3 = d;
        @(posedge clk);
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ra1 = 4'd5; ra2 = 4'd15;
        #1;
        tests_run++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_read: rd1=%h rd2=%h busy=%b, want 0 0 0", rd1, rd2, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        write_a(4'd3, 32'hDEADBEEF);
        ra1 = 4'd3; #1;
        tests_run++;
        if (rd1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL basic_write: rd1=%h want deadbeef", rd1);
        end
        write_a(4'd0, 32'h1234);
        ra1 = 4'd0; #1;
        tests_run++;
        if (rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg: rd1=%h want 0", rd1);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        we3 = 1'b1; wa3 = 4'd7; wd3 = 32'h11;
        we4 = 1'b1; wa4 = 4'd7; wd4 = 32'h22;
        @(posedge clk);
        @(negedge clk);
        wa3 = 4'd2; wd3 = 32'h200;
        wa4 = 4'd9; wd4 = 32'h900;
        ra1 = 4'd7; #1;
        tests_run++;
        if (rd1 !== 32'h22) begin
            tests_failed++;
            $display("FAIL collision_b_wins: rd1=%h want 22", rd1);
        end
        @(posedge clk);
        @(negedge clk);
        we3 = 1'b0; we4 = 1'b0;
        ra1 = 4'd2; ra2 = 4'd9; #1;
        tests_run++;
        if (rd1 !== 32'h200 || rd2 !== 32'h900) begin
            tests_failed++;
            $display("FAIL dual_write: rd1=%h rd2=%h want 200 900", rd1, rd2);
        end
    endtask

    task automatic test_clear;
        int cnt;
        for (int i = 0; i < 16; i++) write_a(AW'(i), 32'h100 + i);
        ra1 = 4'd15; ra2 = 4'd0; #1;
        tests_run++;
        if (rd1 !== 32'h10F || rd2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL fill: rd1=%h rd2=%h want 10f 0", rd1, rd2);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        cnt = 0;
        // At the negedge of loop pass cnt the clear index equals cnt.
        while (busy === 1'b1 && cnt < 40) begin
            we3 = (cnt == 6); wa3 = 4'd4; wd3 = 32'h55;
            clr = (cnt == 8);
            if (cnt == 6) begin
                ra1 = 4'd12; ra2 = 4'd3; #1;
                tests_run++;
                if (rd1 !== 32'h10C || rd2 !== 32'h0) begin
                    tests_failed++;
                    $display("FAIL read_during_clear: rd1=%h rd2=%h want 10c 0", rd1, rd2);
                end
            end
            cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        we3 = 1'b0; clr = 1'b0;
        tests_run++;
        if (cnt != 16) begin
            tests_failed++;
            $display("FAIL busy_cycles: got %0d want 16", cnt);
        end
        for (int i = 0; i < 16; i++) begin
            ra1 = AW'(i); #1;
            tests_run++;
            if (rd1 !== 32'h0) begin
                tests_failed++;
                $display("FAIL cleared_reg%0d: rd1=%h want 0", i, rd1);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        write_a(4'd10, 32'hAAAA);
        write_a(4'd14, 32'hEEEE);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_before_abort: busy=%b want 1", busy);
        end
        rst_n = 1'b0; #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_busy: busy=%b want 0", busy);
        end
        for (int i = 0; i < 16; i++) begin
            ra1 = AW'(i); #1;
            tests_run++;
            if (rd1 !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_reg%0d: rd1=%h want 0", i, rd1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        we3 = 1'b1; wa3 = 4'd10; wd3 = 32'h1010;
        @(posedge clk);
        @(negedge clk);
        we3 = 1'b0;
        ra1 = 4'd10; #1;
        tests_run++;
        if (rd1 !== 32'h1010 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_after_reset: rd1=%h busy=%b want 1010 0", rd1, busy);
        end
    endtask

    task automatic test_bypass;
        logic [WIDTH-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'hA5;
`else
        exp_pre = 32'h77;
`endif
        @(negedge clk);
        we4 = 1'b1; wa4 = 4'd5; wd4 = 32'h77;
        @(posedge clk);
        @(negedge clk);
        wd4 = 32'hA5; ra2 = 4'd5; ra1 = 4'd0; #1;
        tests_run++;
        if (rd2 !== exp_pre) begin
            tests_failed++;
            $display("FAIL bypass_pre_edge: rd2=%h want %h", rd2, exp_pre);
        end
        @(posedge clk);
        @(negedge clk);
        we4 = 1'b1; wa4 = 4'd0; wd4 = 32'hBEEF; #1;
        tests_run++;
        if (rd2 !== 32'hA5 || rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL bypass_post_edge: rd2=%h rd1=%h want a5 0", rd2, rd1);
        end
        @(posedge clk);
        @(negedge clk);
        we4 = 1'b0; #1;
        tests_run++;
        if (rd1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_reg_port_b: rd1=%h want 0", rd1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the register count (2..256).
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning that register 0 is hardwired to zero.
REQ-004 The block SHALL derive localparam AW = $clog2(DEPTH), meaning the address width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, active on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have ports ra1 and ra2, input, AW bits each: the read addresses.
REQ-008 The block SHALL have ports rd1 and rd2, output, WIDTH bits each: the read data.
REQ-009 The block SHALL have port we3, input, 1 bit: write enable, port A.
REQ-010 The block SHALL have ports wa3 (AW bits) and wd3 (WIDTH bits), input: port A address and data.
REQ-011 The block SHALL have port we4, input, 1 bit: write enable, port B.
REQ-012 The block SHALL have ports wa4 (AW bits) and wd4 (WIDTH bits), input: port B address and data.
REQ-013 The block SHALL have port clr, input, 1 bit: a one-cycle request to start a bulk clear.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a bulk clear is in progress.

Function
REQ-015 Reads SHALL be combinational: rd1 = reg[ra1] and rd2 = reg[ra2], with zero cycles of latency.
REQ-016 A write SHALL update reg[wa] at the rising edge of clk when its enable is high and busy is 0.
REQ-017 If we3 and we4 are both high with wa3 == wa4, port B (wd4) SHALL win.
REQ-018 If ZERO_REG = 1, a read of address 0 SHALL return 0 and writes to address 0 SHALL be ignored.
REQ-019 An address >= DEPTH (non-power-of-2 DEPTH) SHALL read as 0, and a write to it SHALL be ignored.
REQ-020 The clear FSM SHALL have two states: IDLE and CLEAR.
REQ-021 In IDLE, clr = 1 SHALL move the FSM to CLEAR at the next edge, with the clear index set to 0.
REQ-022 In CLEAR, the block SHALL zero reg[index] on each edge and increment the index, taking DEPTH cycles in total.
REQ-023 When index == DEPTH-1, the block SHALL clear that entry and return to IDLE at the same edge.
REQ-024 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-025 clr asserted while in CLEAR SHALL be ignored; the clear SHALL NOT restart.
REQ-026 we3 and we4 asserted while busy = 1 SHALL be dropped, not queued.
REQ-027 Reads during CLEAR SHALL return the current contents, so entries not yet cleared keep their old values.
REQ-028 clr together with we3 or we4 in the IDLE cycle SHALL perform the write, then start the clear.

Reset
REQ-029 While rst_n = 0, all registers SHALL be 0, the FSM SHALL be in IDLE, the clear index SHALL be 0 and busy SHALL be 0, independent of clk.
REQ-030 rst_n asserted in the middle of a clear SHALL abort it immediately, so busy = 0 in the same cycle.
REQ-031 rst_n deassertion SHALL take effect at the first rising clk edge after release.

Configuration
REQ-032 The block SHALL use macro REGFILE_BYPASS_EN to compile write-to-read forwarding in or out.
REQ-033 With REGFILE_BYPASS_EN defined, if busy = 0, a write enable is high and wa == ra (with a legal, writable address), rd SHALL return the write data in the same cycle; wd4 SHALL take precedence over wd3.
REQ-034 Without REGFILE_BYPASS_EN, rd SHALL return the stored value, and new data SHALL be visible only after the write edge.

Verification
REQ-035 The bench SHALL cover reset then read: rst_n = 0, ra1 = 5, ra2 = 15 -> rd1 = rd2 = 0 and busy = 0.
REQ-036 The bench SHALL cover a basic write: we3 = 1, wa3 = 3, wd3 = 0xDEADBEEF, one edge, ra1 = 3 -> rd1 = 0xDEADBEEF; with ZERO_REG = 1, wa3 = 0, wd3 = 0x1234 -> rd of address 0 = 0.
REQ-037 The bench SHALL cover a dual-write collision: we3 = we4 = 1, wa3 = wa4 = 7, wd3 = 0x11, wd4 = 0x22 -> reg7 = 0x22; wa3 = 2 and wa4 = 9 in one cycle -> both updated.
REQ-038 The bench SHALL cover a bulk clear: fill all 16 registers, pulse clr -> busy = 1 for exactly 16 cycles; a write of 0x55 to register 4 during the clear is dropped; a second clr pulse mid-clear is ignored; all registers = 0 after busy falls.
REQ-039 The bench SHALL cover reset mid-clear: rst_n = 0 at clear cycle 6 -> busy = 0 immediately and all registers = 0; after release, a write to register 10 succeeds on the first edge.
REQ-040 The bench SHALL cover bypass: we4 = 1, wa4 = 5, wd4 = 0xA5, ra2 = 5 before the edge -> rd2 = 0xA5 with REGFILE_BYPASS_EN defined, and the old value without it.
